fb_scanout: RTL and testbench

- Read-side counterpart to the rasterizer's framebuffer write port.
- Scans a double-buffered 320x240, 4-bit-per-pixel framebuffer and drives 640x480@60 VGA timing, with 2x pixel/line doubling and a writable 16-entry palette.
- Performs tear-free front/back buffer swaps at vertical blanking on request from the frame controller.

---
 rtl/fb_scanout_if.sv | 38 +++
 rtl/fb_scanout.sv | 185 ++++++++++++++++++
 tb/tb_fb_scanout.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: bundles the scanout engine's bus signals.
//   pix_ce                 pixel tick enable (asserted at most every 2nd clk)
//   fb_raddr / fb_rdata    framebuffer read port (data valid 1 clk after address)
//   pal_we/pal_idx/pal_data palette write port, data is {R,G,B} 4 bits each
//   swap_req / swap_ack    buffer swap handshake, front_buf = buffer scanned
//   vga_r/g/b, hsync, vsync, blank, frame_start   VGA output side
// slave  : the scanout engine.
// master : the environment (frame controller, memory, display sink).
interface fb_scanout_if;
  logic        pix_ce;
  logic [17:0] fb_raddr;
  logic [3:0]  fb_rdata;
  logic        pal_we;
  logic [3:0]  pal_idx;
  logic [11:0] pal_data;
  logic        swap_req;
  logic        swap_ack;
  logic        front_buf;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;

  modport slave (
    input  pix_ce, fb_rdata, pal_we, pal_idx, pal_data, swap_req,
    output fb_raddr, swap_ack, front_buf, vga_r, vga_g, vga_b,
           hsync, vsync, blank, frame_start
  );

  modport master (
    output pix_ce, fb_rdata, pal_we, pal_idx, pal_data, swap_req,
    input  fb_raddr, swap_ack, front_buf, vga_r, vga_g, vga_b,
           hsync, vsync, blank, frame_start
  );
endinterface

// File: rtl/fb_scanout.sv
// fb_scanout: scans a double-buffered 4bpp framebuffer out as VGA with 2x
// pixel/line doubling, a 16-entry writable palette and tear-free buffer swaps
// taken at the start of vertical blanking.
// Ports:
//   clk     system clock
//   sreset  synchronous active-high reset
//   bus     fb_scanout_if.slave (pixel enable, framebuffer read port,
//           palette write port, swap handshake, VGA outputs)
// Pipeline: stage 0 issues the read address, stage 1 captures the palette
// index, stage 2 looks up the colour. Sync/blank flags travel alongside, so
// every VGA output lags the counters by exactly two pixel ticks.
module fb_scanout #(
  parameter int FB_W      = 320,
  parameter int FB_H      = 240,
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int BUF1_BASE = 76800
) (
  input logic          clk,
  input logic          sreset,
  fb_scanout_if.slave  bus
);

  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int HS_END = HS_BEG + H_SYNC - 1;
  localparam int VS_BEG = V_VIS + V_FP;
  localparam int VS_END = VS_BEG + V_SYNC - 1;

  logic [9:0]  hcnt_r, vcnt_r;
  logic        front_r, pending_r, swap_ack_r, frame_start_r;
  // stage 0: address plus flags (hs/vs kept as active-low levels)
  logic [17:0] raddr_r;
  logic        v0_r, vis0_r, hs0_r, vs0_r;
  // stage 1: palette index plus flags
  logic        v1_r, vis1_r, hs1_r, vs1_r;
  logic [3:0]  idx1_r;
  // stage 2: registered VGA outputs
  logic [11:0] rgb_r;
  logic        blank_r, hsync_r, vsync_r;
  logic [11:0] pal_r [16];

  logic        h_last_s, v_last_s, vis_s, hs_s, vs_s, take_s;
  logic [17:0] row_s, col_s, base_s, addr_s;

  // Counter decode, read address generation and swap decision
  always_comb begin
    h_last_s = (hcnt_r == 10'(H_TOT - 1));
    v_last_s = (vcnt_r == 10'(V_TOT - 1));
    vis_s    = (hcnt_r < 10'(H_VIS)) && (vcnt_r < 10'(V_VIS));
    hs_s     = !((hcnt_r >= 10'(HS_BEG)) && (hcnt_r <= 10'(HS_END)));
    vs_s     = !((vcnt_r >= 10'(VS_BEG)) && (vcnt_r <= 10'(VS_END)));
    // Outside the visible area clamp to the last row/column so the address
    // always stays inside the front buffer.
    if (vcnt_r < 10'(V_VIS)) begin
      row_s = {9'd0, vcnt_r[9:1]};
    end else begin
      row_s = 18'(FB_H - 1);
    end
    if (hcnt_r < 10'(H_VIS)) begin
      col_s = {9'd0, hcnt_r[9:1]};
    end else begin
      col_s = 18'(FB_W - 1);
    end
    if (front_r) begin
      base_s = 18'(BUF1_BASE);
    end else begin
      base_s = 18'd0;
    end
    addr_s = base_s + row_s * 18'(FB_W) + col_s;
    // A request arriving in the swap-tick clk itself is honoured.
    take_s = bus.pix_ce && (hcnt_r == 10'd0) && (vcnt_r == 10'(V_VIS)) &&
             (pending_r || bus.swap_req);
  end

  // Raster counters, advanced on pixel ticks only
  always_ff @(posedge clk) begin
    if (sreset) begin
      hcnt_r <= 10'd0;
      vcnt_r <= 10'd0;
    end else if (bus.pix_ce) begin
      if (h_last_s) begin
        hcnt_r <= 10'd0;
        if (v_last_s) begin
          vcnt_r <= 10'd0;
        end else begin
          vcnt_r <= vcnt_r + 10'd1;
        end
      end else begin
        hcnt_r <= hcnt_r + 10'd1;
      end
    end
  end

  // Swap request tracking, front buffer select and frame_start pulse
  always_ff @(posedge clk) begin
    if (sreset) begin
      front_r       <= 1'b0;
      pending_r     <= 1'b0;
      swap_ack_r    <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      swap_ack_r    <= take_s;
      frame_start_r <= bus.pix_ce && h_last_s && v_last_s;
      if (take_s) begin
        front_r   <= ~front_r;
        pending_r <= 1'b0;
      end else if (bus.swap_req) begin
        pending_r <= 1'b1;
      end
    end
  end

  // Three-stage scanout pipeline; idle stages emit blanked, sync-inactive output
  always_ff @(posedge clk) begin
    if (sreset) begin
      raddr_r <= 18'd0;
      v0_r    <= 1'b0;
      vis0_r  <= 1'b0;
      hs0_r   <= 1'b1;
      vs0_r   <= 1'b1;
      v1_r    <= 1'b0;
      vis1_r  <= 1'b0;
      hs1_r   <= 1'b1;
      vs1_r   <= 1'b1;
      idx1_r  <= 4'd0;
      rgb_r   <= 12'd0;
      blank_r <= 1'b1;
      hsync_r <= 1'b1;
      vsync_r <= 1'b1;
    end else if (bus.pix_ce) begin
      raddr_r <= addr_s;
      v0_r    <= 1'b1;
      vis0_r  <= vis_s;
      hs0_r   <= hs_s;
      vs0_r   <= vs_s;
      v1_r    <= v0_r;
      vis1_r  <= vis0_r;
      hs1_r   <= hs0_r;
      vs1_r   <= vs0_r;
      idx1_r  <= bus.fb_rdata;
      if (v1_r) begin
        rgb_r   <= vis1_r ? pal_r[idx1_r] : 12'd0;
        blank_r <= !vis1_r;
        hsync_r <= hs1_r;
        vsync_r <= vs1_r;
      end else begin
        rgb_r   <= 12'd0;
        blank_r <= 1'b1;
        hsync_r <= 1'b1;
        vsync_r <= 1'b1;
      end
    end
  end

  // Palette storage: grey ramp after reset, writable on any clk
  always_ff @(posedge clk) begin
    if (sreset) begin
      for (int i = 0; i < 16; i++) begin
        pal_r[i] <= {4'(i), 4'(i), 4'(i)};
      end
    end else if (bus.pal_we) begin
      pal_r[bus.pal_idx] <= bus.pal_data;
    end
  end

  assign bus.fb_raddr    = raddr_r;
  assign bus.swap_ack    = swap_ack_r;
  assign bus.front_buf   = front_r;
  assign bus.vga_r       = rgb_r[11:8];
  assign bus.vga_g       = rgb_r[7:4];
  assign bus.vga_b       = rgb_r[3:0];
  assign bus.hsync       = hsync_r;
  assign bus.vsync       = vsync_r;
  assign bus.blank       = blank_r;
  assign bus.frame_start = frame_start_r;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout with reduced raster timing so several full frames fit
// in a short run. A tick-indexed reference model predicts every output.
module tb_fb_scanout;
  localparam int FB_W = 16, FB_H = 12;
  localparam int H_VIS = 32, H_FP = 4, H_SYNC = 6, H_BP = 4;
  localparam int V_VIS = 24, V_FP = 2, V_SYNC = 2, V_BP = 3;
  localparam int BUF1 = 192;
  localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;   // 46
  localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;   // 31
  localparam int FRAME = HT * VT;                     // 1426
  localparam int HS_BEG = H_VIS + H_FP;
  localparam int VS_BEG = V_VIS + V_FP;

  logic clk = 1'b0;
  logic sreset;
  fb_scanout_if bus();

  fb_scanout #(
    .FB_W(FB_W), .FB_H(FB_H),
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .BUF1_BASE(BUF1)
  ) dut (
    .clk(clk),
    .sreset(sreset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // memory content: either low address nibble or constant 5
  bit mem_mode;
  function automatic logic [3:0] mem_fn(input logic [17:0] a);
    if (mem_mode) return 4'd5;
    return a[3:0];
  endfunction

  always @(posedge clk) bus.fb_rdata <= mem_fn(bus.fb_raddr);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic [3:0] idx;
  } ent_t;

  int total = 0, bad = 0;
  int tick_no = 0;
  bit m_front, m_pend;
  logic [11:0] m_pal [16];
  ent_t m_q[$];
  logic [17:0] e_raddr;
  bit e_rvis, e_blank, e_hs, e_vs, e_ack, e_fs, e_front;
  logic [11:0] e_rgb;
  bit last_ce, rnd_pal, rnd_swap;
  int swap_a = -1, swap_b = -1;
  int hs_low, vs_low, blank_low, ack_cnt, ack_tick, fs_tick;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (tick %0d, t=%0t)", nm, act, exp, tick_no, $time);
    end
  endtask

  // Reference model: applies the inputs of the coming clk edge
  task automatic model_step();
    int t, h, v;
    ent_t e, o;
    logic [17:0] a;
    e_ack = 1'b0;
    e_fs  = 1'b0;
    if (sreset) begin
      tick_no = 0;
      m_front = 1'b0;
      m_pend  = 1'b0;
      for (int i = 0; i < 16; i++) m_pal[i] = {4'(i), 4'(i), 4'(i)};
      m_q.delete();
      e_raddr = 18'd0; e_rvis = 1'b1;
      e_rgb = 12'd0; e_blank = 1'b1; e_hs = 1'b1; e_vs = 1'b1;
    end else begin
      if (bus.pix_ce) begin
        t = tick_no % FRAME;
        h = t % HT;
        v = t / HT;
        e.vis = (h < H_VIS) && (v < V_VIS);
        e.hs  = !(h >= HS_BEG && h < HS_BEG + H_SYNC);
        e.vs  = !(v >= VS_BEG && v < VS_BEG + V_SYNC);
        a = 18'((m_front ? BUF1 : 0) + (v / 2) * FB_W + h / 2);
        e.idx = mem_fn(a);
        e_raddr = a;
        e_rvis  = e.vis;
        m_q.push_back(e);
        if (m_q.size() > 2) begin
          o = m_q.pop_front();
          e_rgb   = o.vis ? m_pal[o.idx] : 12'd0;
          e_blank = !o.vis;
          e_hs    = o.hs;
          e_vs    = o.vs;
        end
        if (h == 0 && v == V_VIS && (m_pend || bus.swap_req)) begin
          m_front = !m_front;
          m_pend  = 1'b0;
          e_ack   = 1'b1;
        end else if (bus.swap_req) begin
          m_pend = 1'b1;
        end
        if (t == FRAME - 1) e_fs = 1'b1;
        tick_no++;
      end else if (bus.swap_req) begin
        m_pend = 1'b1;
      end
      if (bus.pal_we) m_pal[bus.pal_idx] = bus.pal_data;
    end
    e_front = m_front;
  endtask

  task automatic check_all();
    if (e_rvis) chk("fb_raddr", int'(bus.fb_raddr), int'(e_raddr));
    else chk("fb_raddr_range", int'(bus.fb_raddr < 18'(BUF1 + FB_W * FB_H)), 1);
    chk("rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), int'(e_rgb));
    chk("blank", int'(bus.blank), int'(e_blank));
    chk("hsync", int'(bus.hsync), int'(e_hs));
    chk("vsync", int'(bus.vsync), int'(e_vs));
    chk("swap_ack", int'(bus.swap_ack), int'(e_ack));
    chk("frame_start", int'(bus.frame_start), int'(e_fs));
    chk("front_buf", int'(bus.front_buf), int'(e_front));
    if (last_ce) begin
      if (bus.hsync === 1'b0) hs_low++;
      if (bus.vsync === 1'b0) vs_low++;
      if (bus.blank === 1'b0) blank_low++;
    end
    if (bus.swap_ack === 1'b1) begin ack_cnt++; ack_tick = tick_no; end
    if (bus.frame_start === 1'b1) fs_tick = tick_no;
  endtask

  task automatic cyc(input bit ce, input bit rst);
    bus.pix_ce = ce;
    sreset = rst;
    last_ce = ce && !rst;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    bus.swap_req = 1'b0;
    bus.pal_we = 1'b0;
    sreset = 1'b0;
  endtask

  task automatic rnd_drive();
    if (rnd_pal && $urandom_range(0, 29) == 0) begin
      bus.pal_we   = 1'b1;
      bus.pal_idx  = 4'($urandom_range(0, 15));
      bus.pal_data = 12'($urandom);
    end
    if (rnd_swap && $urandom_range(0, 299) == 0) bus.swap_req = 1'b1;
  endtask

  task automatic run_ticks(input int n);
    int gap;
    for (int k = 0; k < n; k++) begin
      rnd_drive();
      if (tick_no + 1 == swap_a || tick_no + 1 == swap_b) bus.swap_req = 1'b1;
      cyc(1'b1, 1'b0);
      gap = int'($urandom_range(1, 2));
      for (int g = 0; g < gap; g++) begin
        rnd_drive();
        cyc(1'b0, 1'b0);
      end
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b1);
    hs_low = 0; vs_low = 0; blank_low = 0;
    ack_cnt = 0; ack_tick = -1; fs_tick = -1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_raddr", int'(bus.fb_raddr), 0);
    chk("rst_rgb", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 0);
    chk("rst_blank", int'(bus.blank), 1);
    chk("rst_hsync", int'(bus.hsync), 1);
    chk("rst_vsync", int'(bus.vsync), 1);
    chk("rst_front", int'(bus.front_buf), 0);
    chk("rst_ack", int'(bus.swap_ack), 0);
    chk("rst_fs", int'(bus.frame_start), 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.pix_ce = 1'b0; bus.pal_we = 1'b0; bus.pal_idx = 4'd0;
    bus.pal_data = 12'd0; bus.swap_req = 1'b0; sreset = 1'b0;
    mem_mode = 1'b0; rnd_pal = 1'b0; rnd_swap = 1'b0;

    // timing and grey-ramp frame
    do_reset();
    do_reset();
    chk_reset_outputs();
    run_ticks(1);
    chk("first_raddr", int'(bus.fb_raddr), 0);
    run_ticks(12);
    chk("grey_x10_y0", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 12'h555);
    chk("blank_x10_y0", int'(bus.blank), 0);
    run_ticks(148);
    chk("grey_x20_y3", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 12'hAAA);
    run_ticks(1428 - 161);
    chk("hs_low_ticks", hs_low, H_SYNC * VT);
    chk("vs_low_ticks", vs_low, V_SYNC * HT);
    chk("visible_ticks", blank_low, H_VIS * V_VIS);
    chk("first_frame_start", fs_tick, FRAME);
    run_ticks(2 * FRAME + 4 - 1428);
    chk("frame_period", fs_tick, 2 * FRAME);
    chk("no_swap", ack_cnt, 0);

    // palette write with constant memory
    mem_mode = 1'b1;
    do_reset();
    run_ticks(50);
    chk("pal5_default", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 12'h555);
    bus.pal_we = 1'b1; bus.pal_idx = 4'd5; bus.pal_data = 12'hF00;
    cyc(1'b0, 1'b0);
    run_ticks(46);
    chk("pal5_red", int'({bus.vga_r, bus.vga_g, bus.vga_b}), 12'hF00);

    // swap requested mid-frame (twice), then a same-clk request
    mem_mode = 1'b0;
    do_reset();
    swap_a = 10 * HT + 3;
    swap_b = 15 * HT + 7;
    run_ticks(FRAME + 1);
    chk("swap_once", ack_cnt, 1);
    chk("swap_tick", ack_tick, V_VIS * HT + 1);
    chk("front_after_swap", int'(bus.front_buf), 1);
    chk("buf1_origin", int'(bus.fb_raddr), BUF1);
    swap_a = FRAME + V_VIS * HT + 1;
    swap_b = -1;
    run_ticks(swap_a + 4 - (FRAME + 1));
    chk("swap_same_clk", ack_cnt, 2);
    chk("swap_same_tick", ack_tick, swap_a);
    chk("front_back_to_0", int'(bus.front_buf), 0);

    // reset mid-frame drops a pending swap
    do_reset();
    swap_a = 4 * HT;
    run_ticks(15 * HT + 1);
    swap_a = -1;
    do_reset();
    chk_reset_outputs();
    run_ticks(FRAME + 4);
    chk("pending_dropped", ack_cnt, 0);
    chk("front_still_0", int'(bus.front_buf), 0);
    chk("restart_frame_start", fs_tick, FRAME);

    // random palette writes and swap requests
    do_reset();
    rnd_pal = 1'b1;
    rnd_swap = 1'b1;
    run_ticks(3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
